ram_bist: RTL



---
 rtl/ram_bist_pkg.sv | 12 +
 rtl/ram_bist_checker.sv | 56 +++++
 rtl/ram_bist.sv | 112 +++++++++++
 3 files changed

// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared state encoding, default geometry and expected-word helper for the RAM BIST
package ram_bist_pkg;
    typedef enum logic [2:0] {IDLE, WR_A, RD_A, DRN_A, WR_B, RD_B, DRN_B, DONE} state_t;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;
    localparam logic [7:0] DEF_PATTERN = 8'hA5;
    // Background word for a march step: pattern xor address, inverted in the B phases.
    // Computed at 32 bits; callers truncate to their data width.
    function automatic logic [31:0] exp_word(input logic [31:0] pattern, input logic [31:0] addr, input logic inv);
        return inv ? ~(pattern ^ addr) : pattern ^ addr;
    endfunction
endpackage

// File: rtl/ram_bist_checker.sv
// ram_bist_checker: registers each read's expected word/address and compares against RAM data one cycle later
//   clr        : clears error count and first-fail capture at run start
//   issue      : a read is presented to the RAM this cycle
//   exp_in     : expected word for the address being read
//   addr_in    : address being read
//   ram_dout   : registered RAM read data
//   err_cnt    : saturating mismatch count
//   fail_addr  : address of the first mismatch
//   fail_data  : word read at the first mismatch
module ram_bist_checker #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              issue,
    input  logic [DATA_W-1:0] exp_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
);
    logic              vld;
    logic [DATA_W-1:0] exp_q;
    logic [ADDR_W-1:0] addr_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld       <= 1'b0;
            exp_q     <= '0;
            addr_q    <= '0;
            err_cnt   <= '0;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            vld    <= issue;
            exp_q  <= exp_in;
            addr_q <= addr_in;
            if (clr) begin
                err_cnt   <= '0;
                fail_addr <= '0;
                fail_data <= '0;
            end else if (vld && ram_dout != exp_q) begin
                // err_cnt never returns to zero within a run, so zero marks the first mismatch
                if (err_cnt == '0) begin
                    fail_addr <= addr_q;
                    fail_data <= ram_dout;
                end
                if (err_cnt != '1)
                    err_cnt <= err_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/ram_bist.sv
// ram_bist: four-phase march BIST initiator for a single-port synchronous RAM
//   start               : begin a run (sampled only when idle)
//   busy / done         : run in progress / one-cycle completion pulse
//   pass                : last run had no mismatches, held until the next start
//   err_cnt             : saturating mismatch count of the last run
//   fail_addr/fail_data : first mismatching address and the word read there
//   ram_we/addr/din     : RAM control driven while busy; ram_dout is the RAM's registered read data
module ram_bist
    import ram_bist_pkg::*;
#(
    parameter int                 ADDR_W  = DEF_ADDR_W,
    parameter int                 DATA_W  = DEF_DATA_W,
    parameter logic [DATA_W-1:0]  PATTERN = DATA_W'(DEF_PATTERN),
    parameter int                 CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);
    localparam logic [ADDR_W-1:0] MAX = '1;
    state_t            state;
    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] dec;
    logic              clr;
    assign inc = ram_addr + 1'b1;
    assign dec = ram_addr - 1'b1;
    assign clr = (state == IDLE) && start;
    function automatic logic [DATA_W-1:0] ew(input logic [ADDR_W-1:0] a, input logic inv);
        return DATA_W'(exp_word(32'(PATTERN), 32'(a), inv));
    endfunction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state    <= WR_A;
                    busy     <= 1'b1;
                    pass     <= 1'b0;
                    ram_we   <= 1'b1;
                    ram_addr <= '0;
                    ram_din  <= ew('0, 1'b0);
                end
                WR_A: if (ram_addr == MAX) begin
                    state    <= RD_A;
                    ram_we   <= 1'b0;
                    ram_din  <= '0;
                    ram_addr <= '0;
                end else begin
                    ram_addr <= inc;
                    ram_din  <= ew(inc, 1'b0);
                end
                RD_A: if (ram_addr == MAX) state <= DRN_A; else ram_addr <= inc;
                DRN_A: begin
                    state   <= WR_B;
                    ram_we  <= 1'b1;
                    ram_din <= ew(MAX, 1'b1);
                end
                WR_B: if (ram_addr == '0) begin
                    state    <= RD_B;
                    ram_we   <= 1'b0;
                    ram_din  <= '0;
                    ram_addr <= MAX;
                end else begin
                    ram_addr <= dec;
                    ram_din  <= ew(dec, 1'b1);
                end
                RD_B: if (ram_addr == '0) state <= DRN_B; else ram_addr <= dec;
                DRN_B: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    // the last compare landed at the end of DRN_B, so err_cnt is final here
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    pass  <= (err_cnt == '0);
                end
                default: state <= IDLE;
            endcase
        end
    end
    ram_bist_checker #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) u_chk (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .issue     ((state == RD_A) || (state == RD_B)),
        .exp_in    (ew(ram_addr, state == RD_B)),
        .addr_in   (ram_addr),
        .ram_dout  (ram_dout),
        .err_cnt   (err_cnt),
        .fail_addr (fail_addr),
        .fail_data (fail_data)
    );
endmodule
